video_std_ctrl: RTL and testbench

Lock controller for PAL/NTSC VSYNC-period detection. It measures successive VSYNC falling-edge periods and qualifies each against legal range limits. It declares a format only after a run of consistent periods, then supervises the locked state for standard changes or loss of signal. It sits between the raw sync inputs and downstream video logic, and gates CSYNC through only while locked.

---
 rtl/video_std_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_video_std_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_std_ctrl.sv
// Purpose: measures VSYNC falling-edge periods, locks onto PAL/NTSC after a run of consistent periods, supervises lock.
// Latency: a vsync_in fall set up before edge k is processed at edge k+3 (2-flop sync + registered edge detect + FSM).
// Backpressure: none; free-running monitor, outputs are registered levels plus a one-cycle lost_out pulse.
module video_std_ctrl #(
  parameter int unsigned CLK_FREQ           = 250_000,
  parameter int unsigned NTSC_PAL_THRESHOLD = 18,
  parameter int unsigned MIN_PERIOD_MS      = 10,
  parameter int unsigned MAX_PERIOD_MS      = 30,
  parameter int unsigned TIMEOUT_MS         = 50,
  parameter int unsigned LOCK_COUNT         = 4,
  parameter int unsigned MISS_LIMIT         = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        vsync_in,
  input  logic        csync_in,
  input  logic        enable_in,
  input  logic        restart_in,
  output logic [2:0]  format_out,
  output logic        format_valid_out,
  output logic        lock_out,
  output logic        lost_out,
  output logic [31:0] period_out,
  output logic        csync_out
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
  localparam logic [31:0] THR_CYC = 32'(CYC_PER_MS * NTSC_PAL_THRESHOLD);
  localparam logic [31:0] MIN_CYC = 32'(CYC_PER_MS * MIN_PERIOD_MS);
  localparam logic [31:0] MAX_CYC = 32'(CYC_PER_MS * MAX_PERIOD_MS);
  localparam logic [31:0] TO_CYC  = 32'(CYC_PER_MS * TIMEOUT_MS);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0]  MISS_N  = 4'(MISS_LIMIT);

  localparam logic [2:0] FMT_UNK  = 3'b000;
  localparam logic [2:0] FMT_NTSC = 3'b010;
  localparam logic [2:0] FMT_PAL  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_MEASURE,
    S_LOCKED,
    S_LOST
  } state_t;

  state_t      state_q;
  logic        vs_meta_q, vs_sync_q, vs_prev_q, fall_q;
  logic [31:0] cnt_q;
  logic [31:0] period_q;
  logic [3:0]  match_q, miss_q;
  logic [2:0]  cand_q, format_q;
  logic        valid_q, lock_q, lost_q, csync_q;

  logic        p_legal;
  logic [2:0]  p_fmt;
  logic [3:0]  match_d, miss_d;
  logic [2:0]  cand_d;
  logic        timeout;
  logic        lost_trig;

  // Synchronise vsync_in and register its falling edge; idle-high reset avoids a fake fall.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      vs_meta_q <= vsync_in;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      fall_q    <= vs_prev_q & ~vs_sync_q;
    end
  end

  // Classify the running count as a period and derive the match/miss/lost decisions for this cycle.
  always_comb begin
    p_legal = (cnt_q >= MIN_CYC) && (cnt_q <= MAX_CYC);
    p_fmt   = (cnt_q > THR_CYC) ? FMT_PAL : FMT_NTSC;
    match_d = match_q;
    cand_d  = cand_q;
    if (!p_legal) begin
      match_d = 4'd0;
      cand_d  = FMT_UNK;
    end else if (p_fmt == cand_q) begin
      match_d = match_q + 4'd1;
    end else begin
      cand_d  = p_fmt;
      match_d = 4'd1;
    end
    miss_d    = (p_legal && (p_fmt == format_q)) ? 4'd0 : (miss_q + 4'd1);
    timeout   = (cnt_q == TO_CYC) && !fall_q;
    lost_trig = 1'b0;
    if (state_q == S_MEASURE) begin
      lost_trig = timeout;
    end else if (state_q == S_LOCKED) begin
      lost_trig = timeout || (fall_q && (miss_d == MISS_N));
    end
  end

  // Lock FSM with period counter; priority is enable, restart, loss, then normal per-state handling.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      period_q <= 32'd0;
      match_q  <= 4'd0;
      miss_q   <= 4'd0;
      cand_q   <= FMT_UNK;
      format_q <= FMT_UNK;
      valid_q  <= 1'b0;
      lock_q   <= 1'b0;
      lost_q   <= 1'b0;
      csync_q  <= 1'b1;
    end else begin
      lost_q  <= 1'b0;
      csync_q <= 1'b1;
      cnt_q   <= (&cnt_q) ? cnt_q : (cnt_q + 32'd1);
      if (!enable_in) begin
        state_q  <= S_IDLE;
        cnt_q    <= 32'd0;
        period_q <= 32'd0;
        match_q  <= 4'd0;
        miss_q   <= 4'd0;
        cand_q   <= FMT_UNK;
        format_q <= FMT_UNK;
        valid_q  <= 1'b0;
        lock_q   <= 1'b0;
      end else if (restart_in) begin
        // Any coincident fall is dropped so SEEK waits for a fresh reference.
        state_q  <= S_SEEK;
        cnt_q    <= 32'd0;
        match_q  <= 4'd0;
        miss_q   <= 4'd0;
        cand_q   <= FMT_UNK;
        format_q <= FMT_UNK;
        valid_q  <= 1'b0;
        lock_q   <= 1'b0;
      end else if (lost_trig) begin
        state_q  <= S_LOST;
        lost_q   <= 1'b1;
        match_q  <= 4'd0;
        miss_q   <= 4'd0;
        cand_q   <= FMT_UNK;
        format_q <= FMT_UNK;
        valid_q  <= 1'b0;
        lock_q   <= 1'b0;
        if (fall_q) begin
          cnt_q    <= 32'd1;
          period_q <= cnt_q;
        end
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_SEEK;
          S_SEEK: begin
            if (fall_q) begin
              cnt_q   <= 32'd1;
              state_q <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            if (fall_q) begin
              cnt_q    <= 32'd1;
              period_q <= cnt_q;
              match_q  <= match_d;
              cand_q   <= cand_d;
              if (match_d == LOCK_N) begin
                state_q  <= S_LOCKED;
                format_q <= cand_d;
                valid_q  <= 1'b1;
                lock_q   <= 1'b1;
                miss_q   <= 4'd0;
                csync_q  <= csync_in;
              end
            end
          end
          S_LOCKED: begin
            csync_q <= csync_in;
            if (fall_q) begin
              cnt_q    <= 32'd1;
              period_q <= cnt_q;
              miss_q   <= miss_d;
            end
          end
          S_LOST:  state_q <= S_SEEK;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign format_out       = format_q;
  assign format_valid_out = valid_q;
  assign lock_out         = lock_q;
  assign lost_out         = lost_q;
  assign period_out       = period_q;
  assign csync_out        = csync_q;

endmodule

// File: tb/tb_video_std_ctrl.sv
// Purpose: directed self-checking bench for video_std_ctrl (acquire, boundaries, loss, control).
// Latency: checks sample 1 time unit after the active edge; a fall driven now is visible after 4 edges.
// Backpressure: none; stimulus is a fixed linear sequence.
module tb_video_std_ctrl;

  // Clock scaled to 25 kHz so every millisecond limit is a tenth of the default cycle counts.
  localparam int TB_CLK_FREQ = 25_000;
  localparam int PN  = 417;  // NTSC field period
  localparam int PP  = 500;  // PAL field period
  localparam int THR = 450;
  localparam int MIN = 250;
  localparam int MAX = 750;
  localparam int TO  = 1250;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        vsync_in;
  logic        csync_in;
  logic        enable_in;
  logic        restart_in;
  logic [2:0]  format_out;
  logic        format_valid_out;
  logic        lock_out;
  logic        lost_out;
  logic [31:0] period_out;
  logic        csync_out;

  int checks = 0;
  int errors = 0;

  video_std_ctrl #(.CLK_FREQ(TB_CLK_FREQ)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .vsync_in         (vsync_in),
    .csync_in         (csync_in),
    .enable_in        (enable_in),
    .restart_in       (restart_in),
    .format_out       (format_out),
    .format_valid_out (format_valid_out),
    .lock_out         (lock_out),
    .lost_out         (lost_out),
    .period_out       (period_out),
    .csync_out        (csync_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive a vsync fall and wait until the controller has acted on it.
  task automatic fall4();
    vsync_in = 1'b0;
    tick(4);
    vsync_in = 1'b1;
  endtask

  // Next fall arrives n cycles after the previous one; 'spent' cycles were already used since fall4 returned.
  task automatic gap_fall(input int n, input int spent);
    tick(n - 4 - spent);
    fall4();
  endtask

  initial begin
    rst_n_in   = 1'b0;
    vsync_in   = 1'b1;
    csync_in   = 1'b0;
    enable_in  = 1'b0;
    restart_in = 1'b0;
    tick(2);
    chk("rst_format", 32'(format_out), 32'd0);
    chk("rst_valid", 32'(format_valid_out), 32'd0);
    chk("rst_lock", 32'(lock_out), 32'd0);
    chk("rst_lost", 32'(lost_out), 32'd0);
    chk("rst_period", period_out, 32'd0);
    chk("rst_csync", 32'(csync_out), 32'd1);
    rst_n_in = 1'b1;
    tick(2);
    enable_in = 1'b1;
    tick(2);

    // NTSC acquisition: reference fall plus four 417-cycle periods.
    fall4();
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    chk("ntsc_not_yet", 32'(lock_out), 32'd0);
    tick(PN - 4);
    vsync_in = 1'b0;
    tick(3);
    chk("ntsc_latency", 32'(lock_out), 32'd0);
    tick(1);
    vsync_in = 1'b1;
    chk("ntsc_lock", 32'(lock_out), 32'd1);
    chk("ntsc_format", 32'(format_out), 32'd2);
    chk("ntsc_valid", 32'(format_valid_out), 32'd1);
    chk("ntsc_period", period_out, 32'(PN));
    chk("csync_at_lock", 32'(csync_out), 32'd0);
    csync_in = 1'b1;
    tick(1);
    chk("csync_follow_hi", 32'(csync_out), 32'd1);
    csync_in = 1'b0;
    tick(1);
    chk("csync_follow_lo", 32'(csync_out), 32'd0);

    // Boundaries while locked NTSC: THR+1 misses, THR clears, MIN clears, MIN-1 misses.
    gap_fall(THR + 1, 2);
    chk("b_451_miss1", 32'(lock_out), 32'd1);
    chk("b_451_period", period_out, 32'(THR + 1));
    gap_fall(THR, 0);
    chk("b_450_ntsc", 32'(lock_out), 32'd1);
    gap_fall(MIN, 0);
    chk("b_250_legal", 32'(lock_out), 32'd1);
    gap_fall(MIN - 1, 0);
    chk("b_249_miss1", 32'(lock_out), 32'd1);
    gap_fall(THR + 1, 0);
    chk("b_second_miss_lost", 32'(lost_out), 32'd1);
    chk("b_second_miss_lock", 32'(lock_out), 32'd0);
    chk("b_second_miss_fmt", 32'(format_out), 32'd0);
    chk("b_second_miss_valid", 32'(format_valid_out), 32'd0);
    tick(1);
    chk("b_lost_one_cycle", 32'(lost_out), 32'd0);

    // Relock NTSC, then stop vsync and expect the timeout.
    gap_fall(PN, 1);
    chk("seek_no_capture", period_out, 32'(THR + 1));
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    chk("relock_t_lock", 32'(lock_out), 32'd1);
    tick(TO - 1);
    chk("to_before_lost", 32'(lost_out), 32'd0);
    chk("to_before_lock", 32'(lock_out), 32'd1);
    tick(1);
    chk("to_lost", 32'(lost_out), 32'd1);
    chk("to_lock", 32'(lock_out), 32'd0);
    chk("to_fmt", 32'(format_out), 32'd0);
    chk("to_csync", 32'(csync_out), 32'd1);
    tick(1);
    chk("to_lost_end", 32'(lost_out), 32'd0);

    // PAL acquisition with the third interval shortened to an illegal 120 cycles.
    fall4();
    gap_fall(PP, 0);
    gap_fall(PP, 0);
    gap_fall(120, 0);
    chk("glitch_period", period_out, 32'd120);
    gap_fall(PP, 0);
    gap_fall(PP, 0);
    gap_fall(PP, 0);
    chk("pal_not_yet", 32'(lock_out), 32'd0);
    gap_fall(PP, 0);
    chk("pal_lock", 32'(lock_out), 32'd1);
    chk("pal_format", 32'(format_out), 32'd4);
    chk("pal_valid", 32'(format_valid_out), 32'd1);
    chk("pal_period", period_out, 32'(PP));

    // PAL upper boundary, then a standard change to NTSC.
    gap_fall(MAX + 1, 0);
    chk("b_751_miss1", 32'(lock_out), 32'd1);
    chk("b_751_period", period_out, 32'(MAX + 1));
    gap_fall(MAX, 0);
    chk("b_750_legal", 32'(lock_out), 32'd1);
    gap_fall(PN, 0);
    chk("chg_first_keep", 32'(lock_out), 32'd1);
    chk("chg_first_fmt", 32'(format_out), 32'd4);
    gap_fall(PN, 0);
    chk("chg_lost", 32'(lost_out), 32'd1);
    chk("chg_fmt", 32'(format_out), 32'd0);
    chk("chg_lock", 32'(lock_out), 32'd0);
    tick(1);
    chk("chg_lost_end", 32'(lost_out), 32'd0);
    gap_fall(PN, 1);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    chk("chg_relock_not_yet", 32'(lock_out), 32'd0);
    gap_fall(PN, 0);
    chk("chg_relock", 32'(lock_out), 32'd1);
    chk("chg_relock_fmt", 32'(format_out), 32'd2);

    // Restart coincident with a fall: no lost pulse and the fall is not a reference.
    tick(PN - 4);
    vsync_in = 1'b0;
    tick(3);
    restart_in = 1'b1;
    tick(1);
    restart_in = 1'b0;
    vsync_in   = 1'b1;
    chk("rst_fall_lock", 32'(lock_out), 32'd0);
    chk("rst_fall_fmt", 32'(format_out), 32'd0);
    chk("rst_fall_valid", 32'(format_valid_out), 32'd0);
    chk("rst_fall_lost", 32'(lost_out), 32'd0);
    chk("rst_fall_period", period_out, 32'(PN));
    tick(1);
    chk("rst_fall_lost_late", 32'(lost_out), 32'd0);
    gap_fall(300, 1);
    chk("rst_next_is_ref", period_out, 32'(PN));
    gap_fall(400, 0);
    chk("rst_first_period", period_out, 32'd400);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    chk("rst_relock", 32'(lock_out), 32'd1);

    // Disable while locked clears everything on the next edge.
    enable_in = 1'b0;
    tick(1);
    chk("dis_lock", 32'(lock_out), 32'd0);
    chk("dis_fmt", 32'(format_out), 32'd0);
    chk("dis_valid", 32'(format_valid_out), 32'd0);
    chk("dis_period", period_out, 32'd0);
    chk("dis_csync", 32'(csync_out), 32'd1);
    chk("dis_lost", 32'(lost_out), 32'd0);

    // Asynchronous reset in the middle of a lock.
    enable_in = 1'b1;
    tick(2);
    fall4();
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    gap_fall(PN, 0);
    chk("ar_locked", 32'(lock_out), 32'd1);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("ar_lock", 32'(lock_out), 32'd0);
    chk("ar_fmt", 32'(format_out), 32'd0);
    chk("ar_valid", 32'(format_valid_out), 32'd0);
    chk("ar_period", period_out, 32'd0);
    chk("ar_csync", 32'(csync_out), 32'd1);
    tick(2);
    rst_n_in = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
